// File: rtl/lu_new_pkg.sv
// Shared types and constants for the LU block-processing CPU datapath.
// Addresses are {page, row, col} into the block memories.
package lu_new;

    localparam int N_BLK      = 32;
    localparam int IDX_W      = $clog2(N_BLK);
    localparam int CPU_ADDR_W = 2 * IDX_W + 1;

    typedef logic [IDX_W-1:0]      t_cpu_idx;
    typedef logic [CPU_ADDR_W-1:0] t_cpu_addr;

    // valid is the MSB so the delay line can find it without knowing the layout
    typedef struct packed {
        logic      valid;
        t_cpu_addr addr;
        logic      wr_top;
        logic      wr_left;
        logic      wr_cur;
    } t_cpu_wr_beat;

    function automatic t_cpu_addr cpu_addr(input logic page, input t_cpu_idx row, input t_cpu_idx col);
        return {page, row, col};
    endfunction

endpackage

// File: rtl/lu_delay_line.sv
// Fixed-depth shift register with synchronous reset of every stage.
// Also reports whether any stage holds a word whose VALID_BIT is set.
module lu_delay_line #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 1,
    parameter int VALID_BIT = WIDTH - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_any_valid
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

    always_comb begin
        stage_d[0] = i_data;
        for (int n = 1; n < DEPTH; n++) begin
            stage_d[n] = stage_q[n-1];
        end
    end

    always_comb begin
        o_any_valid = 1'b0;
        for (int n = 0; n < DEPTH; n++) begin
            o_any_valid = o_any_valid | stage_q[n][VALID_BIT];
        end
    end

    // NOTE: every stage is reset, so beats in flight at reset are dropped rather than written.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign o_data = stage_q[DEPTH-1];

endmodule

// File: rtl/cpu_idx_addr_gen.sv
// k/i/j loop counters plus read-address register and write-address delay line
// sitting between the CPU pipeline controller and the block memories.
module cpu_idx_addr_gen
    import lu_new::*;
#(
    parameter int PIPE_LAT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_k_reset,
    input  logic                  i_k_inc,
    input  logic                  i_i_reset,
    input  logic                  i_i_inc,
    input  logic                  i_i_load_k1,
    input  logic                  i_j_reset,
    input  logic                  i_j_inc,
    input  logic                  i_j_load_k,
    input  logic                  i_j_load_k1,
    output logic                  o_k_done,
    output logic                  o_i_done,
    output logic                  o_j_done,
    input  logic                  i_valid,
    input  logic                  i_norm,
    input  logic                  i_recip,
    input  logic                  i_wr_top,
    input  logic                  i_wr_left,
    input  logic                  i_wr_cur,
    input  logic                  i_whichpage,
    output logic                  o_rd_valid,
    output logic                  o_rd_norm,
    output logic                  o_rd_recip,
    output logic [CPU_ADDR_W-1:0] o_rd_addr_cur,
    output logic [CPU_ADDR_W-1:0] o_rd_addr_top,
    output logic [CPU_ADDR_W-1:0] o_rd_addr_left,
    output logic [CPU_ADDR_W-1:0] o_rd_addr_pivot,
    output logic                  o_wr_valid,
    output logic                  o_wr_top,
    output logic                  o_wr_left,
    output logic                  o_wr_cur,
    output logic [CPU_ADDR_W-1:0] o_wr_addr,
    output logic                  o_pipe_empty
);

    localparam int       BEAT_W = $bits(t_cpu_wr_beat);
    localparam t_cpu_idx IDX_MAX = t_cpu_idx'(N_BLK - 1);
    localparam t_cpu_idx IDX_ONE = t_cpu_idx'(1);

    t_cpu_idx     k_q, k_d, i_q, i_d, j_q, j_d;
    logic         rd_valid_q, rd_valid_d, rd_norm_q, rd_norm_d, rd_recip_q, rd_recip_d;
    t_cpu_addr    rd_cur_q, rd_cur_d, rd_top_q, rd_top_d;
    t_cpu_addr    rd_left_q, rd_left_d, rd_pivot_q, rd_pivot_d;
    t_cpu_wr_beat wr_beat_q, wr_beat_d, wr_beat_out;
    logic [BEAT_W-1:0] wr_out_bits;
    logic         wr_any_valid;

    // Counter width equals IDX_W, so +1 and k+1 wrap mod N_BLK for free.
    always_comb begin
        k_d = k_q;
        if (i_k_reset)      k_d = '0;
        else if (i_k_inc)   k_d = k_q + IDX_ONE;

        i_d = i_q;
        if (i_i_reset)        i_d = '0;
        else if (i_i_load_k1) i_d = k_q + IDX_ONE;
        else if (i_i_inc)     i_d = i_q + IDX_ONE;

        j_d = j_q;
        if (i_j_reset)        j_d = '0;
        else if (i_j_load_k1) j_d = k_q + IDX_ONE;
        else if (i_j_load_k)  j_d = k_q;
        else if (i_j_inc)     j_d = j_q + IDX_ONE;
    end

    // NOTE: every output of this block gets a default first, so hold-when-idle cannot infer a latch.
    always_comb begin
        rd_valid_d = i_valid;
        rd_norm_d  = i_valid & i_norm;
        rd_recip_d = i_valid & i_recip;
        rd_cur_d   = rd_cur_q;
        rd_top_d   = rd_top_q;
        rd_left_d  = rd_left_q;
        rd_pivot_d = rd_pivot_q;
        if (i_valid) begin
            rd_cur_d   = cpu_addr(i_whichpage, i_q, j_q);
            rd_top_d   = cpu_addr(i_whichpage, k_q, j_q);
            rd_left_d  = cpu_addr(i_whichpage, i_q, k_q);
            rd_pivot_d = cpu_addr(i_whichpage, k_q, k_q);
        end

        wr_beat_d.valid   = i_valid;
        wr_beat_d.addr    = cpu_addr(i_whichpage, i_q, j_q);
        wr_beat_d.wr_top  = i_valid & i_wr_top;
        wr_beat_d.wr_left = i_valid & i_wr_left;
        wr_beat_d.wr_cur  = i_valid & i_wr_cur;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            k_q        <= '0;
            i_q        <= '0;
            j_q        <= '0;
            rd_valid_q <= 1'b0;
            rd_norm_q  <= 1'b0;
            rd_recip_q <= 1'b0;
            rd_cur_q   <= '0;
            rd_top_q   <= '0;
            rd_left_q  <= '0;
            rd_pivot_q <= '0;
            wr_beat_q  <= '0;
        end else begin
            k_q        <= k_d;
            i_q        <= i_d;
            j_q        <= j_d;
            rd_valid_q <= rd_valid_d;
            rd_norm_q  <= rd_norm_d;
            rd_recip_q <= rd_recip_d;
            rd_cur_q   <= rd_cur_d;
            rd_top_q   <= rd_top_d;
            rd_left_q  <= rd_left_d;
            rd_pivot_q <= rd_pivot_d;
            wr_beat_q  <= wr_beat_d;
        end
    end

    lu_delay_line #(
        .WIDTH     (BEAT_W),
        .DEPTH     (PIPE_LAT),
        .VALID_BIT (BEAT_W - 1)
    ) u_wr_delay (
        .clk         (clk),
        .reset       (reset),
        .i_data      (wr_beat_q),
        .o_data      (wr_out_bits),
        .o_any_valid (wr_any_valid)
    );

    assign wr_beat_out = t_cpu_wr_beat'(wr_out_bits);

    assign o_k_done        = (k_q == IDX_MAX);
    assign o_i_done        = (i_q == IDX_MAX);
    assign o_j_done        = (j_q == IDX_MAX);
    assign o_rd_valid      = rd_valid_q;
    assign o_rd_norm       = rd_norm_q;
    assign o_rd_recip      = rd_recip_q;
    assign o_rd_addr_cur   = rd_cur_q;
    assign o_rd_addr_top   = rd_top_q;
    assign o_rd_addr_left  = rd_left_q;
    assign o_rd_addr_pivot = rd_pivot_q;
    assign o_wr_valid      = wr_beat_out.valid;
    assign o_wr_top        = wr_beat_out.valid & wr_beat_out.wr_top;
    assign o_wr_left       = wr_beat_out.valid & wr_beat_out.wr_left;
    assign o_wr_cur        = wr_beat_out.valid & wr_beat_out.wr_cur;
    assign o_wr_addr       = wr_beat_out.addr;
    // The read register is the head of the write path, so it counts as in flight too.
    assign o_pipe_empty    = ~(rd_valid_q | wr_any_valid);

endmodule

// File: tb/tb_cpu_idx_addr_gen.sv
// Directed bench for cpu_idx_addr_gen: an integer/queue reference model checked
// every cycle, plus hand-computed literal expectations for the key scenarios.
module tb_cpu_idx_addr_gen;
    import lu_new::*;

    localparam int PIPE_LAT = 8;

    logic clk = 1'b0;
    logic reset;
    logic i_k_reset, i_k_inc, i_i_reset, i_i_inc, i_i_load_k1;
    logic i_j_reset, i_j_inc, i_j_load_k, i_j_load_k1;
    logic o_k_done, o_i_done, o_j_done;
    logic i_valid, i_norm, i_recip, i_wr_top, i_wr_left, i_wr_cur, i_whichpage;
    logic o_rd_valid, o_rd_norm, o_rd_recip;
    logic [CPU_ADDR_W-1:0] o_rd_addr_cur, o_rd_addr_top, o_rd_addr_left, o_rd_addr_pivot;
    logic o_wr_valid, o_wr_top, o_wr_left, o_wr_cur;
    logic [CPU_ADDR_W-1:0] o_wr_addr;
    logic o_pipe_empty;

    always #5 clk = ~clk;

    cpu_idx_addr_gen #(.PIPE_LAT(PIPE_LAT)) dut (
        .clk(clk), .reset(reset),
        .i_k_reset(i_k_reset), .i_k_inc(i_k_inc),
        .i_i_reset(i_i_reset), .i_i_inc(i_i_inc), .i_i_load_k1(i_i_load_k1),
        .i_j_reset(i_j_reset), .i_j_inc(i_j_inc), .i_j_load_k(i_j_load_k), .i_j_load_k1(i_j_load_k1),
        .o_k_done(o_k_done), .o_i_done(o_i_done), .o_j_done(o_j_done),
        .i_valid(i_valid), .i_norm(i_norm), .i_recip(i_recip),
        .i_wr_top(i_wr_top), .i_wr_left(i_wr_left), .i_wr_cur(i_wr_cur),
        .i_whichpage(i_whichpage),
        .o_rd_valid(o_rd_valid), .o_rd_norm(o_rd_norm), .o_rd_recip(o_rd_recip),
        .o_rd_addr_cur(o_rd_addr_cur), .o_rd_addr_top(o_rd_addr_top),
        .o_rd_addr_left(o_rd_addr_left), .o_rd_addr_pivot(o_rd_addr_pivot),
        .o_wr_valid(o_wr_valid), .o_wr_top(o_wr_top), .o_wr_left(o_wr_left), .o_wr_cur(o_wr_cur),
        .o_wr_addr(o_wr_addr), .o_pipe_empty(o_pipe_empty)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int due;
        int addr;
        bit top;
        bit left;
        bit cur;
    } wr_rec_t;

    wr_rec_t wq[$];
    int  cyc = 0;
    bit  model_ok = 1'b0;
    int  m_k, m_i, m_j, ok, oi, oj;
    bit  m_rd_valid, m_rd_norm, m_rd_recip;
    int  m_cur, m_top, m_left, m_pivot;

    function automatic int addr_of(input bit page, input int row, input int col);
        return int'(page) * N_BLK * N_BLK + row * N_BLK + col;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_k = 0; m_i = 0; m_j = 0;
            m_rd_valid = 0; m_rd_norm = 0; m_rd_recip = 0;
            m_cur = 0; m_top = 0; m_left = 0; m_pivot = 0;
            wq.delete();
            model_ok = 1'b1;
        end else if (model_ok) begin
            ok = m_k; oi = m_i; oj = m_j;
            m_rd_valid = i_valid;
            m_rd_norm  = i_valid && i_norm;
            m_rd_recip = i_valid && i_recip;
            if (i_valid) begin
                m_cur   = addr_of(i_whichpage, oi, oj);
                m_top   = addr_of(i_whichpage, ok, oj);
                m_left  = addr_of(i_whichpage, oi, ok);
                m_pivot = addr_of(i_whichpage, ok, ok);
                wq.push_back('{cyc + PIPE_LAT, m_cur, i_wr_top, i_wr_left, i_wr_cur});
            end
            if (i_k_reset)    m_k = 0;
            else if (i_k_inc) m_k = (ok + 1) % N_BLK;
            if (i_i_reset)        m_i = 0;
            else if (i_i_load_k1) m_i = (ok + 1) % N_BLK;
            else if (i_i_inc)     m_i = (oi + 1) % N_BLK;
            if (i_j_reset)        m_j = 0;
            else if (i_j_load_k1) m_j = (ok + 1) % N_BLK;
            else if (i_j_load_k)  m_j = ok;
            else if (i_j_inc)     m_j = (oj + 1) % N_BLK;
            while (wq.size() > 0 && wq[0].due < cyc) void'(wq.pop_front());
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            bit exp_wr;
            exp_wr = (wq.size() > 0) && (wq[0].due == cyc);
            check("k_done",    o_k_done,   32'(m_k == N_BLK - 1));
            check("i_done",    o_i_done,   32'(m_i == N_BLK - 1));
            check("j_done",    o_j_done,   32'(m_j == N_BLK - 1));
            check("rd_valid",  o_rd_valid, 32'(m_rd_valid));
            check("rd_norm",   o_rd_norm,  32'(m_rd_norm));
            check("rd_recip",  o_rd_recip, 32'(m_rd_recip));
            check("rd_cur",    32'(o_rd_addr_cur),   m_cur);
            check("rd_top",    32'(o_rd_addr_top),   m_top);
            check("rd_left",   32'(o_rd_addr_left),  m_left);
            check("rd_pivot",  32'(o_rd_addr_pivot), m_pivot);
            check("wr_valid",  o_wr_valid, 32'(exp_wr));
            check("wr_top",    o_wr_top,   32'(exp_wr && wq[0].top));
            check("wr_left",   o_wr_left,  32'(exp_wr && wq[0].left));
            check("wr_cur",    o_wr_cur,   32'(exp_wr && wq[0].cur));
            if (exp_wr) check("wr_addr", 32'(o_wr_addr), wq[0].addr);
            check("pipe_empty", o_pipe_empty, 32'(wq.size() == 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        i_k_reset = 0; i_k_inc = 0; i_i_reset = 0; i_i_inc = 0; i_i_load_k1 = 0;
        i_j_reset = 0; i_j_inc = 0; i_j_load_k = 0; i_j_load_k1 = 0;
        i_valid = 0; i_norm = 0; i_recip = 0;
        i_wr_top = 0; i_wr_left = 0; i_wr_cur = 0; i_whichpage = 0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // 1: reset state
        check("t1_empty",  o_pipe_empty, 1);
        check("t1_kdone",  o_k_done, 0);
        check("t1_idone",  o_i_done, 0);
        check("t1_jdone",  o_j_done, 0);
        check("t1_wr",     o_wr_valid, 0);
        check("t1_rd",     o_rd_valid, 0);
        tick();

        // 2: k=3, load i/j with k+1, then walk i through the wrap
        for (int n = 0; n < 3; n++) begin idle(); i_k_inc = 1; tick(); end
        idle(); i_i_load_k1 = 1; i_j_load_k1 = 1; tick();
        for (int n = 0; n < 27; n++) begin idle(); i_i_inc = 1; tick(); end
        idle();
        check("t2_idone_31", o_i_done, 1);
        i_i_inc = 1; tick(); idle();
        check("t2_idone_0",  o_i_done, 0);
        i_valid = 1; tick(); idle();
        check("t2_cur",   32'(o_rd_addr_cur),   32'h004);
        check("t2_top",   32'(o_rd_addr_top),   32'h064);
        check("t2_left",  32'(o_rd_addr_left),  32'h003);
        check("t2_pivot", 32'(o_rd_addr_pivot), 32'h063);

        // 3: k to 31, i_load_k1 wraps to 0; k_inc with j_load_k1 from k=5
        for (int n = 0; n < 28; n++) begin idle(); i_k_inc = 1; tick(); end
        idle();
        check("t3_kdone", o_k_done, 1);
        i_i_load_k1 = 1; tick(); idle();
        i_k_reset = 1; tick(); idle();
        for (int n = 0; n < 5; n++) begin idle(); i_k_inc = 1; tick(); end
        idle(); i_k_inc = 1; i_j_load_k1 = 1; tick(); idle();
        i_valid = 1; tick(); idle();
        check("t3_cur",   32'(o_rd_addr_cur),   32'h006);
        check("t3_pivot", 32'(o_rd_addr_pivot), 32'h0C6);

        // 4: k=2, i=7, j=9, page 1
        i_k_reset = 1; i_i_reset = 1; i_j_reset = 1; tick();
        for (int n = 0; n < 9; n++) begin
            idle(); i_k_inc = (n < 2); i_i_inc = (n < 7); i_j_inc = 1; tick();
        end
        idle(); i_valid = 1; i_whichpage = 1; i_wr_cur = 1; tick(); idle();
        check("t4_rd_valid", o_rd_valid, 1);
        check("t4_cur",   32'(o_rd_addr_cur),   32'h4E9);
        check("t4_top",   32'(o_rd_addr_top),   32'h449);
        check("t4_left",  32'(o_rd_addr_left),  32'h4E2);
        check("t4_pivot", 32'(o_rd_addr_pivot), 32'h442);
        check("t4_empty", o_pipe_empty, 0);
        i_wr_top = 1; tick(); idle();  // strobe without i_valid must never write
        repeat (6) tick();
        check("t4_wr_early", o_wr_valid, 0);
        tick();
        check("t4_wr_valid", o_wr_valid, 1);
        check("t4_wr_cur",   o_wr_cur, 1);
        check("t4_wr_top",   o_wr_top, 0);
        check("t4_wr_addr",  32'(o_wr_addr), 32'h4E9);
        tick();
        check("t4_wr_gone",  o_wr_valid, 0);
        repeat (3) tick();

        // 5: five back-to-back beats; cycle 0 is the first issue
        idle(); i_valid = 1; i_wr_cur = 1; i_j_inc = 1; tick();
        for (int n = 1; n < 16; n++) begin
            check($sformatf("t5_empty_c%0d", n), o_pipe_empty, 32'(!(n >= 1 && n <= 13)));
            check($sformatf("t5_wr_c%0d", n),    o_wr_valid,   32'(n >= 9 && n <= 13));
            idle();
            if (n < 5) begin
                i_valid = 1; i_norm = n[0]; i_recip = (n == 2);
                i_wr_top = (n == 1); i_wr_left = (n == 3); i_wr_cur = 1; i_j_inc = 1;
            end
            tick();
        end

        // 6: reset with four beats in flight
        for (int n = 0; n < 4; n++) begin
            idle(); i_valid = 1; i_wr_top = 1; i_k_inc = 1; tick();
        end
        idle(); reset = 1'b1; tick(); reset = 1'b0;
        check("t6_empty", o_pipe_empty, 1);
        check("t6_rd",    o_rd_valid, 0);
        for (int n = 0; n < 12; n++) begin
            check("t6_no_wr", o_wr_valid, 0);
            tick();
        end
        i_valid = 1; i_whichpage = 1; tick(); idle();
        check("t6_cur",   32'(o_rd_addr_cur),   32'h400);
        check("t6_pivot", 32'(o_rd_addr_pivot), 32'h400);
        repeat (12) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_idx_addr_gen.md
Name: cpu_idx_addr_gen

Overview:
- Loop-index and address stage directly downstream of the CPU pipeline controller.
- Holds the k/i/j loop counters, which the controller drives through reset/inc/load strobes and reads back as done flags.
- Turns each valid controller beat into registered read addresses for the cur/top/left/pivot block memories.
- Carries the matching write address and write enables through a fixed-latency delay line aligned with the arithmetic pipeline, and reports pipeline-empty back to the controller.

Parameters:
N_BLK, 32, block dimension; counters span 0..N_BLK-1 (must be a power of 2).
IDX_W, 5, index width = log2(N_BLK).
PIPE_LAT, 8, cycles from read-address outputs to write-address outputs (arithmetic pipeline depth, >=1).

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
i_k_reset, i_k_inc  in  1 each  k counter controls
i_i_reset, i_i_inc, i_i_load_k1  in  1 each  i counter controls
i_j_reset, i_j_inc, i_j_load_k, i_j_load_k1  in  1 each  j counter controls
o_k_done, o_i_done, o_j_done  out  1 each  counter == N_BLK-1
i_valid, i_norm, i_recip  in  1 each  beat issue and op flags
i_wr_top, i_wr_left, i_wr_cur  in  1 each  write targets for this beat
i_whichpage  in  1  buffer page select (address MSB)
o_rd_valid, o_rd_norm, o_rd_recip  out  1 each  registered beat and op flags
o_rd_addr_cur, o_rd_addr_top, o_rd_addr_left, o_rd_addr_pivot  out  2*IDX_W+1 each  read addresses
o_wr_valid, o_wr_top, o_wr_left, o_wr_cur  out  1 each  delayed write enables
o_wr_addr  out  2*IDX_W+1  delayed write address
o_pipe_empty  out  1  no beat in flight

Behaviour:
- Reset is synchronous:
  - Clears k, i, j to 0.
  - Clears the read register and every delay-line stage; all valid and enable outputs go to 0 and all addresses to 0.
  - o_pipe_empty = 1.
  - Applies mid-operation too: in-flight beats are discarded, not written.
- Counters update each cycle with this priority:
  - k: k_reset -> 0; else k_inc -> k+1 mod N_BLK.
  - i: i_reset -> 0; else i_load_k1 -> k+1; else i_inc -> i+1.
  - j: j_reset -> 0; else j_load_k1 -> k+1; else j_load_k -> k; else j_inc -> j+1.
  - Arithmetic is mod N_BLK, so inc at N_BLK-1 wraps to 0 and load_k1 with k=N_BLK-1 gives 0.
  - Loads always use the pre-update k. Example: k_inc together with j_load_k1 leaves j == new k.
- Done flags are combinational from the registered counters: o_x_done = (x == N_BLK-1). No dependence on same-cycle strobes.
- Address format is {page, row[IDX_W-1:0], col[IDX_W-1:0]}, where page = i_whichpage sampled on the issuing cycle.
- Read stage, one register with latency 1: on a cycle with i_valid=1, the next cycle presents
  - o_rd_valid=1, o_rd_norm=i_norm, o_rd_recip=i_recip
  - cur={i,j}, top={k,j}, left={i,k}, pivot={k,k}, all using the pre-update counters of the issuing cycle.
  - With i_valid=0: o_rd_valid=0, flags 0, addresses hold their last value.
- Write path:
  - {valid, addr=cur address, wr_top, wr_left, wr_cur} enters the delay line together with the read stage.
  - It emerges exactly PIPE_LAT cycles after o_rd_valid, i.e. PIPE_LAT+1 cycles after i_valid.
  - o_wr_top/left/cur are gated by o_wr_valid. A beat with i_valid=0 never writes even if i_wr_* = 1.
- One beat per cycle is accepted with no back-pressure. Back-to-back beats stay in order with no bubbles.
- o_pipe_empty = NOT(o_rd_valid OR any delay-stage valid), from registers only.
  - It is not combinational on i_valid: the cycle after an issue it is already 0.
  - It returns to 1 in the cycle after the last beat's o_wr_valid.
- i_valid together with any counter strobe in the same cycle: the address uses old counter values and the counters update.

Decomposition:
- Package lu_new gains:
  - constants N_BLK, IDX_W, CPU_ADDR_W = 2*IDX_W+1
  - typedef t_cpu_idx (logic[IDX_W-1:0])
  - typedef t_cpu_addr
  - packed struct t_cpu_wr_beat {valid, addr, wr_top, wr_left, wr_cur}
- Sub-module lu_delay_line #(WIDTH, DEPTH): a shift register with synchronous reset clearing all stages. It is instantiated for t_cpu_wr_beat with DEPTH=PIPE_LAT.

Test Plan:
1. Reset, then idle -> all counters 0, o_pipe_empty=1, o_k_done=o_i_done=o_j_done=0, all enables 0.
2. k=3 (three k_inc); i_load_k1 + j_load_k1 -> i=4, j=4. Then 28 i_inc -> i wraps to 0, and o_i_done=1 only while i=31.
3. k=31, then i_load_k1 -> i=0. k_inc with j_load_k1 from k=5 -> k=6, j=6.
4. k=2, i=7, j=9, page=1, i_valid, i_wr_cur=1 -> next cycle cur=0x4E9, top=0x449, left=0x4E2, pivot=0x442. Nine cycles after issue (PIPE_LAT=8): o_wr_valid=1, o_wr_cur=1, o_wr_addr=0x4E9.
5. Five back-to-back beats then idle -> o_pipe_empty=0 from cycle 1 to cycle 13; writes occur on cycles 9..13 in order; o_pipe_empty=1 at cycle 14.
6. Reset asserted with 4 beats in flight -> no o_wr_valid afterwards, o_pipe_empty=1 the next cycle, counters 0.
